// File: rtl/vm1_bus_pkg.sv
// Shared types and defaults for the vm1 bus-cycle controller.
package vm1_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_RAM_W,
        ST_IO_W,
        ST_VEC,
        ST_REPLY,
        ST_ERR,
        ST_HOLD
    } bus_state_e;

    localparam logic [15:0] IO_BASE_DEF = 16'o160000;
    localparam logic [15:0] VEC_A_DEF   = 16'o060;
    localparam logic [15:0] VEC_B_DEF   = 16'o064;

    function automatic logic [15:0] byte_lane(input logic [15:0] w, input logic hi);
        return {8'h00, hi ? w[15:8] : w[7:0]};
    endfunction

endpackage

// File: rtl/vm1_irq_arb.sv
// Two-source interrupt arbiter: registered requests, A-over-B choice frozen
// at IAKO entry, vector mux and one-clk acknowledge pulses.
module vm1_irq_arb
    import vm1_bus_pkg::*;
#(
    parameter logic [15:0] VEC_A = VEC_A_DEF,
    parameter logic [15:0] VEC_B = VEC_B_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        irq_a,
    input  logic        irq_b,
    input  logic        vec_start,
    input  logic        vec_done,
    output logic        virq,
    output logic [15:0] vec,
    output logic        iack_a,
    output logic        iack_b
);
    logic req_a_q, req_a_d, req_b_q, req_b_d;
    logic sel_a_q, sel_a_d;
    logic iack_a_q, iack_a_d, iack_b_q, iack_b_d;

    always_comb begin
        req_a_d  = req_a_q;
        req_b_d  = req_b_q;
        sel_a_d  = sel_a_q;
        iack_a_d = vec_done & sel_a_q;
        iack_b_d = vec_done & ~sel_a_q;
        if (ce) begin
            req_a_d = irq_a;
            req_b_d = irq_b;
        end
        if (vec_start) begin
            sel_a_d = req_a_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_a_q  <= 1'b0;
            req_b_q  <= 1'b0;
            sel_a_q  <= 1'b0;
            iack_a_q <= 1'b0;
            iack_b_q <= 1'b0;
        end else begin
            req_a_q  <= req_a_d;
            req_b_q  <= req_b_d;
            sel_a_q  <= sel_a_d;
            iack_a_q <= iack_a_d;
            iack_b_q <= iack_b_d;
        end
    end

    assign virq   = req_a_q | req_b_q;
    assign vec    = sel_a_q ? VEC_A : VEC_B;
    assign iack_a = iack_a_q;
    assign iack_b = iack_b_q;

endmodule

// File: rtl/vm1_bus_ctl.sv
// vm1 bus-cycle controller: turns SYNC/DIN/DOUT cycles into RAM, I/O or
// interrupt-vector accesses, generating RPLY and bus error.
module vm1_bus_ctl
    import vm1_bus_pkg::*;
#(
    parameter int unsigned RAM_WAIT = 1,
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [15:0] IO_BASE  = IO_BASE_DEF,
    parameter logic [15:0] VEC_A    = VEC_A_DEF,
    parameter logic [15:0] VEC_B    = VEC_B_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        sync,
    input  logic        din,
    input  logic        dout,
    input  logic        wtbt,
    input  logic        iako,
    input  logic [15:0] addr,
    input  logic [15:0] cpu_do,
    output logic        rply,
    output logic [15:0] cpu_di,
    output logic        error,
    output logic        virq,
    output logic        ram_req,
    output logic        ram_we,
    output logic [1:0]  ram_be,
    output logic [14:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic        io_sel,
    output logic        io_we,
    output logic [15:0] io_addr,
    output logic [15:0] io_wdata,
    input  logic [15:0] io_rdata,
    input  logic        io_ack,
    input  logic        irq_a,
    input  logic        irq_b,
    output logic        iack_a,
    output logic        iack_b
);
    localparam logic [7:0] RAM_WAIT_C = 8'(RAM_WAIT);
    localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);

    bus_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic        we_q, we_d, byte_q, byte_d, ram_req_q, ram_req_d;
    logic        vec_start, vec_done;
    logic [15:0] vec;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        we_d      = we_q;
        byte_d    = byte_q;
        ram_req_d = 1'b0;
        vec_start = 1'b0;
        vec_done  = 1'b0;
        if (ce) begin
            // Losing SYNC mid-cycle abandons the access without any reply.
            if (state_q != ST_IDLE && !sync) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: if (sync && (din || dout)) begin
                        state_d = ST_DECODE;
                        addr_d  = addr;
                        wdata_d = cpu_do;
                        we_d    = dout;
                        byte_d  = wtbt;
                        cnt_d   = 8'd0;
                    end
                    ST_DECODE: begin
                        cnt_d = 8'd0;
                        if (iako && din) begin
                            state_d   = ST_VEC;
                            vec_start = 1'b1;
                        end else if (addr_q < IO_BASE) begin
                            state_d   = ST_RAM_W;
                            ram_req_d = 1'b1;
                        end else begin
                            state_d = ST_IO_W;
                        end
                    end
                    ST_RAM_W: if (cnt_q == RAM_WAIT_C) begin
                        rdata_d = we_q ? 16'h0000 :
                                  byte_q ? byte_lane(ram_rdata, addr_q[0]) : ram_rdata;
                        state_d = ST_REPLY;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    ST_IO_W: if (io_ack) begin
                        rdata_d = we_q ? 16'h0000 :
                                  byte_q ? byte_lane(io_rdata, addr_q[0]) : io_rdata;
                        state_d = ST_REPLY;
                    end else if (cnt_q == TIMEOUT_C) begin
                        state_d = ST_ERR;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    ST_VEC: begin
                        rdata_d  = vec;
                        vec_done = 1'b1;
                        state_d  = ST_REPLY;
                    end
                    ST_REPLY: if (!din && !dout) begin
                        state_d = ST_HOLD;
                    end
                    ST_ERR: if (cnt_q == 8'd1) begin
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            addr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            rdata_q   <= 16'h0000;
            we_q      <= 1'b0;
            byte_q    <= 1'b0;
            ram_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            we_q      <= we_d;
            byte_q    <= byte_d;
            ram_req_q <= ram_req_d;
        end
    end

    vm1_irq_arb #(
        .VEC_A (VEC_A),
        .VEC_B (VEC_B)
    ) u_irq_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .irq_a     (irq_a),
        .irq_b     (irq_b),
        .vec_start (vec_start),
        .vec_done  (vec_done),
        .virq      (virq),
        .vec       (vec),
        .iack_a    (iack_a),
        .iack_b    (iack_b)
    );

    assign rply      = (state_q == ST_REPLY);
    assign cpu_di    = rply ? rdata_q : 16'h0000;
    assign error     = (state_q == ST_ERR);
    assign io_sel    = (state_q == ST_IO_W);
    assign io_we     = io_sel & we_q;
    assign io_addr   = io_sel ? addr_q : 16'h0000;
    assign io_wdata  = io_sel ? wdata_q : 16'h0000;
    assign ram_req   = ram_req_q;
    assign ram_we    = ram_req_q & we_q;
    // Byte writes steer the replicated byte to one lane; everything else is a full word.
    assign ram_be    = !ram_req_q ? 2'b00 :
                       (we_q && byte_q) ? (addr_q[0] ? 2'b10 : 2'b01) : 2'b11;
    assign ram_addr  = addr_q[15:1];
    assign ram_wdata = (we_q && byte_q) ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q;

endmodule

// File: tb/tb_vm1_bus_ctl.sv
// Scoreboard bench for vm1_bus_ctl: drives vm1 bus cycles against a simple RAM
// and I/O responder and compares replies with queued expectations.
module tb_vm1_bus_ctl;
    localparam int RW     = 1;
    localparam int TO     = 16;
    localparam int BUDGET = 60;

    logic        clk = 0, reset_n = 1, ce = 1;
    logic        sync = 0, din = 0, dout = 0, wtbt = 0, iako = 0;
    logic [15:0] addr = 0, cpu_do = 0, io_rdata = 0;
    logic        io_ack = 0, irq_a = 0, irq_b = 0;
    logic        rply, error, virq, ram_req, ram_we, io_sel, io_we, iack_a, iack_b;
    logic [15:0] cpu_di, ram_wdata, ram_rdata, io_addr, io_wdata;
    logic [1:0]  ram_be;
    logic [14:0] ram_addr;

    int n_chk = 0, n_fail = 0;
    logic [15:0] exp_q[$];

    bit   [15:0] mem [0:32767];
    logic [14:0] rd_addr = '0;

    typedef struct {
        logic [15:0] data;
        int          rply_lat;
        int          err_lat;
        int          err_len;
        int          req_cnt;
        logic [1:0]  be;
        logic [15:0] wdata;
        logic        ram_we;
        int          ia_cnt;
        int          ib_cnt;
        logic        io_we;
        logic [15:0] io_wdata;
        logic [15:0] io_addr;
        logic        rply_after_drop;
    } res_t;

    vm1_bus_ctl #(
        .RAM_WAIT (RW),
        .TIMEOUT  (TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .sync(sync), .din(din), .dout(dout), .wtbt(wtbt), .iako(iako),
        .addr(addr), .cpu_do(cpu_do),
        .rply(rply), .cpu_di(cpu_di), .error(error), .virq(virq),
        .ram_req(ram_req), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .io_sel(io_sel), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ack(io_ack),
        .irq_a(irq_a), .irq_b(irq_b), .iack_a(iack_a), .iack_b(iack_b)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: strobe captures address, data follows on the next clock.
    always @(posedge clk) begin
        if (ram_req) begin
            if (ram_we && ram_be[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
            if (ram_we && ram_be[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
            rd_addr <= ram_addr;
        end
    end
    assign ram_rdata = mem[rd_addr];

    task automatic bus_cycle(input logic [15:0] a, input logic wr, input logic bt, input logic ia,
                             input logic [15:0] wd, input int ack_after, input logic [15:0] io_rd,
                             output res_t r);
        logic io_seen;
        io_seen = 1'b0;
        r.data = 0; r.rply_lat = -1; r.err_lat = -1; r.err_len = 0; r.req_cnt = 0;
        r.be = 0; r.wdata = 0; r.ram_we = 0; r.ia_cnt = 0; r.ib_cnt = 0;
        r.io_we = 0; r.io_wdata = 0; r.io_addr = 0; r.rply_after_drop = 0;
        addr = a; cpu_do = wd; wtbt = bt; iako = ia; din = ~wr; dout = wr; sync = 1;
        for (int k = 0; k < BUDGET; k++) begin
            @(posedge clk); #1;
            if (ram_req) begin r.req_cnt++; r.be = ram_be; r.wdata = ram_wdata; r.ram_we = ram_we; end
            if (iack_a) r.ia_cnt++;
            if (iack_b) r.ib_cnt++;
            if (io_sel && !io_seen) begin
                io_seen = 1'b1; r.io_we = io_we; r.io_wdata = io_wdata; r.io_addr = io_addr;
            end
            if (error) begin
                if (r.err_lat < 0) r.err_lat = k;
                r.err_len++;
            end else if (r.err_lat >= 0) begin
                break;
            end
            if (rply) begin r.rply_lat = k; r.data = cpu_di; break; end
            if (k == ack_after) begin io_ack = 1; io_rdata = io_rd; end
        end
        io_ack = 0; din = 0; dout = 0; iako = 0; wtbt = 0;
        @(posedge clk); #1;
        r.rply_after_drop = rply;
        if (iack_a) r.ia_cnt++;
        if (iack_b) r.ib_cnt++;
        if (ram_req) r.req_cnt++;
        sync = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2 reset_n = 0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if ({rply, error, virq, ram_req, ram_we, ram_be, io_sel, io_we, iack_a, iack_b} !== 11'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0", {rply, error, virq, ram_req, ram_we, ram_be, io_sel, io_we, iack_a, iack_b});
        end
        n_chk++; if ({cpu_di, ram_addr, ram_wdata, io_addr, io_wdata} !== 79'b0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", {cpu_di, ram_addr, ram_wdata, io_addr, io_wdata});
        end
        @(negedge clk) reset_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        res_t r;
        logic [15:0] e;
        bus_cycle(16'o001000, 1, 0, 0, 16'o012345, -1, 0, r);
        n_chk++; if (r.req_cnt !== 1) begin n_fail++; $display("FAIL word_wr_req: got %0d want 1", r.req_cnt); end
        n_chk++; if (r.be !== 2'b11) begin n_fail++; $display("FAIL word_wr_be: got %b want 11", r.be); end
        n_chk++; if (r.ram_we !== 1'b1) begin n_fail++; $display("FAIL word_wr_we: got %b want 1", r.ram_we); end
        n_chk++; if (r.wdata !== 16'o012345) begin n_fail++; $display("FAIL word_wr_data: got %o want 012345", r.wdata); end
        n_chk++; if (r.rply_lat !== RW + 2) begin n_fail++; $display("FAIL word_wr_lat: got %0d want %0d", r.rply_lat, RW + 2); end
        exp_q.push_back(16'o012345);
        bus_cycle(16'o001000, 0, 0, 0, 16'h0, -1, 0, r);
        e = exp_q.pop_front();
        n_chk++; if (r.data !== e) begin n_fail++; $display("FAIL word_rd_data: got %o want %o", r.data, e); end
        n_chk++; if (r.rply_lat !== RW + 2) begin n_fail++; $display("FAIL word_rd_lat: got %0d want %0d", r.rply_lat, RW + 2); end
        n_chk++; if (r.rply_after_drop !== 1'b0) begin n_fail++; $display("FAIL word_rd_drop: rply got %b want 0", r.rply_after_drop); end
        n_chk++; if (r.ram_we !== 1'b0) begin n_fail++; $display("FAIL word_rd_we: got %b want 0", r.ram_we); end
    endtask

    task automatic test_byte();
        res_t r;
        logic [15:0] e;
        bus_cycle(16'o001001, 1, 1, 0, 16'o000277, -1, 0, r);
        n_chk++; if (r.be !== 2'b10) begin n_fail++; $display("FAIL byte_wr_be: got %b want 10", r.be); end
        n_chk++; if (r.wdata !== 16'hBFBF) begin n_fail++; $display("FAIL byte_wr_data: got %h want bfbf", r.wdata); end
        exp_q.push_back(16'o000277);
        bus_cycle(16'o001001, 0, 1, 0, 16'h0, -1, 0, r);
        e = exp_q.pop_front();
        n_chk++; if (r.data !== e) begin n_fail++; $display("FAIL byte_rd_hi: got %o want %o", r.data, e); end
        exp_q.push_back(16'h00E5);
        bus_cycle(16'o001000, 0, 1, 0, 16'h0, -1, 0, r);
        e = exp_q.pop_front();
        n_chk++; if (r.data !== e) begin n_fail++; $display("FAIL byte_rd_lo: got %h want %h", r.data, e); end
        exp_q.push_back(16'hBFE5);
        bus_cycle(16'o001000, 0, 0, 0, 16'h0, -1, 0, r);
        e = exp_q.pop_front();
        n_chk++; if (r.data !== e) begin n_fail++; $display("FAIL byte_merge: got %h want %h", r.data, e); end
    endtask

    task automatic test_random_ram();
        res_t r;
        logic [15:0] a, d, e;
        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom_range(16'o002000, 16'o157776)) & 16'hFFFE;
            d = 16'($urandom);
            bus_cycle(a, 1, 0, 0, d, -1, 0, r);
            exp_q.push_back(d);
            bus_cycle(a, 0, 0, 0, 16'h0, -1, 0, r);
            e = exp_q.pop_front();
            n_chk++; if (r.data !== e) begin n_fail++; $display("FAIL rand_rd[%0d] @%o: got %h want %h", i, a, r.data, e); end
        end
    endtask

    task automatic test_io();
        res_t r;
        logic [15:0] e;
        bus_cycle(16'o177566, 1, 0, 0, 16'o000101, 3, 0, r);
        n_chk++; if (r.io_we !== 1'b1) begin n_fail++; $display("FAIL io_wr_we: got %b want 1", r.io_we); end
        n_chk++; if (r.io_wdata !== 16'o000101) begin n_fail++; $display("FAIL io_wr_data: got %o want 000101", r.io_wdata); end
        n_chk++; if (r.io_addr !== 16'o177566) begin n_fail++; $display("FAIL io_wr_addr: got %o want 177566", r.io_addr); end
        n_chk++; if (r.rply_lat !== 4) begin n_fail++; $display("FAIL io_wr_lat: got %0d want 4", r.rply_lat); end
        n_chk++; if (r.req_cnt !== 0) begin n_fail++; $display("FAIL io_wr_ramreq: got %0d want 0", r.req_cnt); end
        exp_q.push_back(16'o000123);
        bus_cycle(16'o177560, 0, 0, 0, 16'h0, 1, 16'o000123, r);
        e = exp_q.pop_front();
        n_chk++; if (r.data !== e) begin n_fail++; $display("FAIL io_rd_data: got %o want %o", r.data, e); end
        n_chk++; if (r.rply_lat !== 2) begin n_fail++; $display("FAIL io_rd_lat: got %0d want 2", r.rply_lat); end
    endtask

    task automatic test_timeout();
        res_t r;
        logic [15:0] e;
        bus_cycle(16'o172000, 0, 0, 0, 16'h0, -1, 0, r);
        n_chk++; if (r.err_lat !== TO + 2) begin n_fail++; $display("FAIL tmo_lat: got %0d want %0d", r.err_lat, TO + 2); end
        n_chk++; if (r.err_len !== 2) begin n_fail++; $display("FAIL tmo_len: got %0d want 2", r.err_len); end
        n_chk++; if (r.rply_lat !== -1) begin n_fail++; $display("FAIL tmo_rply: rply at %0d want none", r.rply_lat); end
        exp_q.push_back(16'hBFE5);
        bus_cycle(16'o001000, 0, 0, 0, 16'h0, -1, 0, r);
        e = exp_q.pop_front();
        n_chk++; if (r.data !== e) begin n_fail++; $display("FAIL tmo_recover: got %h want %h", r.data, e); end
    endtask

    task automatic test_irq();
        res_t r;
        logic [15:0] e;
        irq_a = 1; irq_b = 1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (virq !== 1'b1) begin n_fail++; $display("FAIL irq_virq_on: got %b want 1", virq); end
        exp_q.push_back(16'o060);
        bus_cycle(16'o000100, 0, 0, 1, 16'h0, -1, 0, r);
        e = exp_q.pop_front();
        n_chk++; if (r.data !== e) begin n_fail++; $display("FAIL irq_vec_a: got %o want %o", r.data, e); end
        n_chk++; if (r.ia_cnt !== 1 || r.ib_cnt !== 0) begin n_fail++; $display("FAIL irq_ack_a: a=%0d b=%0d want 1/0", r.ia_cnt, r.ib_cnt); end
        n_chk++; if (r.req_cnt !== 0) begin n_fail++; $display("FAIL irq_no_ram: got %0d want 0", r.req_cnt); end
        n_chk++; if (virq !== 1'b1) begin n_fail++; $display("FAIL irq_virq_b_pending: got %b want 1", virq); end
        irq_a = 0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(16'o064);
        bus_cycle(16'o000100, 0, 0, 1, 16'h0, -1, 0, r);
        e = exp_q.pop_front();
        n_chk++; if (r.data !== e) begin n_fail++; $display("FAIL irq_vec_b: got %o want %o", r.data, e); end
        n_chk++; if (r.ia_cnt !== 0 || r.ib_cnt !== 1) begin n_fail++; $display("FAIL irq_ack_b: a=%0d b=%0d want 0/1", r.ia_cnt, r.ib_cnt); end
        irq_b = 0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (virq !== 1'b0) begin n_fail++; $display("FAIL irq_virq_off: got %b want 0", virq); end
    endtask

    task automatic test_sync_abort();
        res_t r;
        logic [15:0] e;
        logic sr, se, si;
        sr = 0; se = 0; si = 0;
        addr = 16'o177570; din = 1; sync = 1;
        repeat (6) @(posedge clk);
        #1;
        n_chk++; if (io_sel !== 1'b1) begin n_fail++; $display("FAIL abort_io_sel: got %b want 1", io_sel); end
        sync = 0; din = 0;
        for (int k = 0; k < TO + 10; k++) begin
            @(posedge clk); #1;
            if (rply) sr = 1;
            if (error) se = 1;
            if (io_sel) si = 1;
        end
        n_chk++; if ({sr, se, si} !== 3'b000) begin n_fail++; $display("FAIL abort_quiet: rply/err/io_sel seen %b want 000", {sr, se, si}); end
        exp_q.push_back(16'o000777);
        bus_cycle(16'o177560, 0, 0, 0, 16'h0, 2, 16'o000777, r);
        e = exp_q.pop_front();
        n_chk++; if (r.data !== e) begin n_fail++; $display("FAIL abort_recover: got %o want %o", r.data, e); end
    endtask

    task automatic test_reset_mid_ram();
        res_t r;
        logic [15:0] e;
        irq_a = 1;
        repeat (2) @(posedge clk);
        #1;
        addr = 16'o001000; din = 1; sync = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_chk++; if (ram_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_req: got %b want 1", ram_req); end
        @(posedge clk); #1;
        reset_n = 0;
        #1;
        n_chk++; if ({rply, error, virq, ram_req, ram_we, ram_be, io_sel, iack_a, iack_b, cpu_di} !== 26'b0) begin
            n_fail++; $display("FAIL rst_mid_outs: got %h want 0", {rply, error, virq, ram_req, ram_we, ram_be, io_sel, iack_a, iack_b, cpu_di});
        end
        irq_a = 0; din = 0; sync = 0;
        @(negedge clk) reset_n = 1;
        @(posedge clk); #1;
        exp_q.push_back(16'hBFE5);
        bus_cycle(16'o001000, 0, 0, 0, 16'h0, -1, 0, r);
        e = exp_q.pop_front();
        n_chk++; if (r.data !== e) begin n_fail++; $display("FAIL rst_mid_recover: got %h want %h", r.data, e); end
    endtask

    task automatic test_ce_gate();
        logic seen;
        seen = 0;
        ce = 0;
        addr = 16'o001000; din = 1; sync = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (ram_req || rply || io_sel) seen = 1;
        end
        din = 0; sync = 0;
        @(posedge clk); #1;
        ce = 1;
        @(posedge clk); #1;
        if (ram_req || rply || io_sel) seen = 1;
        n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL ce_gate: activity %b want 0", seen); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_random_ram();
        test_io();
        test_timeout();
        test_irq();
        test_sync_abort();
        test_reset_mid_ram();
        test_ce_gate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vm1_bus_ctl.md
# vm1_bus_ctl

Bus-cycle controller between the `vm1` core and the memory/peripheral side of the system. It decodes each SYNC/DIN/DOUT cycle into a synchronous RAM access, an I/O register access, or an interrupt-vector read, and generates RPLY. It raises `error_i` on accesses to absent I/O, and it arbitrates two interrupt sources onto VIRQ/IAKO. It replaces ad-hoc RPLY and bus-error logic around the CPU.

## Interface
- `RAM_WAIT`, 1: ce-cycles from RAM strobe to read data valid (1..7).
- `TIMEOUT`, 16: ce-cycles an I/O access waits for `io_ack` before bus error (2..255).
- `IO_BASE`, 16'o160000: addresses ≥ `IO_BASE` are I/O; below are RAM.
- `VEC_A`, 16'o060: vector for source A.
- `VEC_B`, 16'o064: vector for source B.

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `ce`  in  1  CPU clock enable; all state changes only when ce=1
- `sync`, `din`, `dout`, `wtbt`, `iako`  in  1 each  vm1 bus strobes
- `addr`  in  16  vm1 address
- `cpu_do`  in  16  vm1 write data (byte data in [7:0])
- `rply`  out  1  reply to vm1
- `cpu_di`  out  16  read data to vm1; 0 when `rply`=0
- `error`  out  1  bus error to vm1 `error_i`
- `virq`  out  1  interrupt request to vm1
- `ram_req`  out  1  one-clk RAM strobe
- `ram_we`  out  1
- `ram_be`  out  2  byte enables
- `ram_addr`  out  15  word address (`addr[15:1]`)
- `ram_wdata`  out  16
- `ram_rdata`  in  16
- `io_sel`  out  1  held for the whole I/O access
- `io_we`  out  1
- `io_addr`  out  16
- `io_wdata`  out  16
- `io_rdata`  in  16
- `io_ack`  in  1
- `irq_a`, `irq_b`  in  1  level interrupt requests
- `iack_a`, `iack_b`  out  1  one-clk acknowledge pulses

## Operation
- FSM states: IDLE, DECODE, RAM_W, IO_W, VEC, REPLY, ERR, HOLD.
- IDLE → DECODE when `sync` and (`din` or `dout`) are sampled.
- DECODE:
  - `iako & din` → VEC; this has priority over the address decode.
  - Else `addr < IO_BASE` → RAM_W, with `ram_req` pulsed once.
  - Else → IO_W.
- RAM_W:
  - Counts `RAM_WAIT` ce-cycles, then latches `ram_rdata` and goes to REPLY.
  - Writes also wait `RAM_WAIT` cycles.
- Byte write (`wtbt & dout`):
  - `ram_be` = `addr[0]` ? 2'b10 : 2'b01.
  - `ram_wdata` = {`cpu_do[7:0]`, `cpu_do[7:0]`}.
  - Word write: `ram_be` = 2'b11.
- Byte read (`wtbt & din`): `cpu_di` = {8'h00, selected byte}.
- IO_W:
  - On `io_ack`, latch `io_rdata` and go to REPLY.
  - The 8-bit timeout counter reaching `TIMEOUT` → ERR.
- ERR: `error`=1 for exactly 2 ce-cycles, no `rply`, then HOLD.
- VEC:
  - `cpu_di` = `VEC_A` if `irq_a` latched, else `VEC_B`.
  - Pulse matching `iack_x`, then REPLY.
- REPLY: `rply`=1 and `cpu_di` valid until `din` and `dout` are both low; then HOLD.
- HOLD: waits for `sync`=0, then IDLE.
- `virq` is registered `irq_a | irq_b`, updated every ce-cycle. The A/B choice is frozen at IAKO entry into VEC.
- If `sync` drops in any state other than IDLE: abort to IDLE, deassert `io_sel`/`rply`/`error`, no ack pulse.

## Timing
- Reset: all outputs 0, FSM IDLE, counters 0.
- RAM read: `rply` asserts `RAM_WAIT`+2 ce-cycles after strobe sample.
- I/O: `rply` asserts 1 ce-cycle after `io_ack` is sampled.
- Timeout: `error` asserts `TIMEOUT`+2 ce-cycles after strobe sample.
- `iack_a`/`iack_b`: exactly one clk wide, aligned to the VEC exit.
- `ram_req`: exactly one clk wide.
- `rply` deasserts on the ce-cycle after the strobes drop.
- `irq_a` and `irq_b` both high at IAKO → A served. B stays requested; `virq` remains 1.

## Structure
- Package `vm1_bus_pkg`: FSM state enum, default vectors 16'o060/16'o064, `IO_BASE` default.
- One natural sub-module: `vm1_irq_arb` (request registering, priority latch, vector mux, ack pulses).

## Test plan
- Word write 16'o012345 to 16'o001000, then read back → `ram_be`=2'b11, `cpu_di`=16'o012345, `rply` at RAM_WAIT+2.
- Byte write 8'o277 to 16'o001001 → `ram_be`=2'b10, `ram_wdata`=16'hBFBF. Byte read of the same address → `cpu_di`=16'o000277.
- Read 16'o172000 with `io_ack` never asserted → `error` high 2 ce-cycles at cycle 18, no `rply`, FSM back to IDLE after `sync` drops.
- `irq_a`=`irq_b`=1, IAKO read → `cpu_di`=16'o060, `iack_a` pulse. Second IAKO after `irq_a` drops → 16'o064, `iack_b` pulse.
- Write 16'o000101 to 16'o177566 with `io_ack` after 3 cycles → `io_we`=1, `io_wdata`=16'o000101, `rply` 1 cycle after ack.
- `reset_n` low during RAM_W, and `sync` dropped mid-IO_W → all outputs 0 immediately / IDLE with no `rply` or `error`.
